// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg : shared state encodings, light patterns and default durations
// Rev 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        WALK      = 3'd6
    } state_t;

    // {red,yellow,green}
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int DEF_GREEN_SEC  = 5;
    localparam int DEF_YELLOW_SEC = 2;
    localparam int DEF_RED_SEC    = 1;
    localparam int DEF_WALK_SEC   = 4;

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// phase_timer : elapsed-tick counter; done fires on the tick completing a phase
// Rev 1.0
// ============================================================================
`default_nettype none

module phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] duration,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    assign done = advance && ((r_count + 4'd1) == duration);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (advance) begin
            r_count <= r_count + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// traffic_light_ctrl : two-way intersection sequencer with pedestrian walk
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_SEC  = DEF_GREEN_SEC,
    parameter int YELLOW_SEC = DEF_YELLOW_SEC,
    parameter int RED_SEC    = DEF_RED_SEC,
    parameter int WALK_SEC   = DEF_WALK_SEC
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ped_pending;
    logic             r_next_dir;
    logic             w_advance;
    logic             w_done;
    logic             w_enter_walk;
    logic [CNT_W-1:0] w_duration;
    logic [2:0]       w_ns_light;
    logic [2:0]       w_ew_light;
    logic             w_walk;

    assign w_advance = enable & tick;

    always_comb begin
        w_duration = CNT_W'(GREEN_SEC);
        case (r_state)
            NS_GREEN, EW_GREEN:   w_duration = CNT_W'(GREEN_SEC);
            NS_YELLOW, EW_YELLOW: w_duration = CNT_W'(YELLOW_SEC);
            RED_A, RED_B:         w_duration = CNT_W'(RED_SEC);
            WALK:                 w_duration = CNT_W'(WALK_SEC);
            default:              w_duration = CNT_W'(GREEN_SEC);
        endcase
    end

    // State only ever changes on done, so done doubles as the counter clear.
    phase_timer u_phase_timer (
        .clk      (Clk),
        .rst      (reset),
        .clear    (w_done),
        .advance  (w_advance),
        .duration (w_duration),
        .done     (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        if (w_done) begin
            case (r_state)
                NS_GREEN:  w_next_state = NS_YELLOW;
                NS_YELLOW: w_next_state = RED_A;
                RED_A:     w_next_state = r_ped_pending ? WALK : EW_GREEN;
                EW_GREEN:  w_next_state = EW_YELLOW;
                EW_YELLOW: w_next_state = RED_B;
                RED_B:     w_next_state = r_ped_pending ? WALK : NS_GREEN;
                WALK:      w_next_state = r_next_dir ? EW_GREEN : NS_GREEN;
                default:   w_next_state = NS_GREEN;
            endcase
        end
    end

    assign w_enter_walk = (w_next_state == WALK) && (r_state != WALK);

    // Decoded from the next state so the registered lights line up with r_state.
    always_comb begin
        w_ns_light = LIGHT_RED;
        w_ew_light = LIGHT_RED;
        w_walk     = 1'b0;
        case (w_next_state)
            NS_GREEN:  w_ns_light = LIGHT_GRN;
            NS_YELLOW: w_ns_light = LIGHT_YEL;
            EW_GREEN:  w_ew_light = LIGHT_GRN;
            EW_YELLOW: w_ew_light = LIGHT_YEL;
            WALK:      w_walk     = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= NS_GREEN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_ped_pending <= 1'b0;
            r_next_dir    <= 1'b0;
            ped_ack       <= 1'b0;
            walk          <= 1'b0;
            ns_light      <= LIGHT_GRN;
            ew_light      <= LIGHT_RED;
        end else begin
            if (w_enter_walk) begin
                r_ped_pending <= 1'b0;
                r_next_dir    <= (r_state == RED_A);
            end else if (ped_req && (r_state != WALK)) begin
                r_ped_pending <= 1'b1;
            end
            ped_ack  <= w_enter_walk;
            walk     <= w_walk;
            ns_light <= w_ns_light;
            ew_light <= w_ew_light;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// tb_traffic_light_ctrl : directed checks of phase sequencing and walk insertion
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic       ped_req;
    logic       ped_ack;
    logic       walk;
    logic [2:0] ns_light;
    logic [2:0] ew_light;

    int total = 0;
    int bad   = 0;

    // {ped_ack, walk, ns_light, ew_light}
    localparam logic [7:0] P_NSG  = 8'b0_0_001_100;
    localparam logic [7:0] P_NSY  = 8'b0_0_010_100;
    localparam logic [7:0] P_RED  = 8'b0_0_100_100;
    localparam logic [7:0] P_EWG  = 8'b0_0_100_001;
    localparam logic [7:0] P_EWY  = 8'b0_0_100_010;
    localparam logic [7:0] P_WACK = 8'b1_1_100_100;
    localparam logic [7:0] P_WALK = 8'b0_1_100_100;

    traffic_light_ctrl #(
        .GREEN_SEC  (5),
        .YELLOW_SEC (2),
        .RED_SEC    (1),
        .WALK_SEC   (4)
    ) dut (
        .Clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tick     (tick),
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {ped_ack, walk, ns_light, ew_light};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cyc();
        chk(tag, P_NSG);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        tick    = 1'b1;
        ped_req = 1'b0;

        // Free-running cycle, no pedestrians
        do_reset("t1_reset");
        run("t1_nsg", P_NSG, 4);
        run("t1_nsy", P_NSY, 2);
        run("t1_reda", P_RED, 1);
        run("t1_ewg", P_EWG, 5);
        run("t1_ewy", P_EWY, 2);
        run("t1_redb", P_RED, 1);
        run("t1_nsg2", P_NSG, 5);
        run("t1_nsy2", P_NSY, 2);

        // Single-cycle request during NS green
        do_reset("t2_reset");
        ped_req = 1'b1;
        run("t2_nsg_req", P_NSG, 1);
        ped_req = 1'b0;
        run("t2_nsg", P_NSG, 3);
        run("t2_nsy", P_NSY, 2);
        run("t2_reda", P_RED, 1);
        run("t2_walk_ack", P_WACK, 1);
        run("t2_walk", P_WALK, 3);
        run("t2_ewg", P_EWG, 5);
        run("t2_ewy", P_EWY, 2);
        run("t2_redb", P_RED, 1);
        run("t2_nsg_nowalk", P_NSG, 1);

        // Request held high continuously
        ped_req = 1'b1;
        do_reset("t3_reset");
        run("t3_nsg", P_NSG, 4);
        run("t3_nsy", P_NSY, 2);
        run("t3_reda", P_RED, 1);
        run("t3_walk1_ack", P_WACK, 1);
        run("t3_walk1", P_WALK, 3);
        run("t3_ewg", P_EWG, 5);
        run("t3_ewy", P_EWY, 2);
        run("t3_redb", P_RED, 1);
        run("t3_walk2_ack", P_WACK, 1);
        run("t3_walk2", P_WALK, 3);
        run("t3_nsg2", P_NSG, 5);
        run("t3_nsy2", P_NSY, 2);
        run("t3_reda2", P_RED, 1);
        run("t3_walk3_ack", P_WACK, 1);
        ped_req = 1'b0;

        // Enable low freezes timing; missing ticks stall the phase
        do_reset("t4_reset");
        run("t4_nsg", P_NSG, 2);
        enable = 1'b0;
        run("t4_frozen", P_NSG, 10);
        enable = 1'b1;
        run("t4_nsg_rest", P_NSG, 2);
        run("t4_nsy", P_NSY, 2);
        run("t4_reda", P_RED, 1);
        run("t4_ewg", P_EWG, 1);
        tick = 1'b0;
        run("t4_notick", P_EWG, 3);
        tick = 1'b1;
        run("t4_ewg_rest", P_EWG, 4);
        run("t4_ewy", P_EWY, 1);

        // Reset in the middle of WALK
        do_reset("t5_reset");
        ped_req = 1'b1;
        run("t5_nsg_req", P_NSG, 1);
        ped_req = 1'b0;
        run("t5_nsg", P_NSG, 3);
        run("t5_nsy", P_NSY, 2);
        run("t5_reda", P_RED, 1);
        run("t5_walk_ack", P_WACK, 1);
        run("t5_walk", P_WALK, 1);
        do_reset("t5_reset_walk");
        run("t5_nsg_after", P_NSG, 4);
        run("t5_nsy_after", P_NSY, 2);
        run("t5_reda_after", P_RED, 1);
        run("t5_ewg_nowalk", P_EWG, 1);

        // Request coinciding with WALK entry is dropped
        do_reset("t6_reset");
        ped_req = 1'b1;
        run("t6_nsg_req", P_NSG, 1);
        ped_req = 1'b0;
        run("t6_nsg", P_NSG, 3);
        run("t6_nsy", P_NSY, 2);
        run("t6_reda", P_RED, 1);
        ped_req = 1'b1;
        run("t6_walk_ack", P_WACK, 1);
        ped_req = 1'b0;
        run("t6_walk", P_WALK, 3);
        run("t6_ewg", P_EWG, 5);
        run("t6_ewy", P_EWY, 2);
        run("t6_redb", P_RED, 1);
        run("t6_nsg_nowalk", P_NSG, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter GREEN_SEC, default 5, green phase length in ticks (legal 1..15).
REQ-002 SHALL have parameter YELLOW_SEC, default 2, yellow phase length in ticks (legal 1..15).
REQ-003 SHALL have parameter RED_SEC, default 1, all-red clearance length in ticks (legal 1..15).
REQ-004 SHALL have parameter WALK_SEC, default 4, pedestrian walk length in ticks (legal 1..15).
REQ-005 SHALL have port Clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  when low, phase timing freezes; outputs hold.
REQ-008 SHALL have port tick  input  1  one-cycle pulse per second from the 1 Hz divider.
REQ-009 SHALL have port ped_req  input  1  pedestrian request, any-length pulse or level.
REQ-010 SHALL have port ped_ack  output  1  one-cycle pulse on entry to WALK.
REQ-011 SHALL have port ns_light  output  3  {red,yellow,green} north-south, one-hot.
REQ-012 SHALL have port ew_light  output  3  {red,yellow,green} east-west, one-hot.
REQ-013 SHALL have port walk  output  1  high only in WALK state.

Function
REQ-014 SHALL implement states NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, WALK; all outputs registered.
REQ-015 SHALL advance the phase counter (4 bits) only in cycles with enable=1 and tick=1; otherwise hold it.
REQ-016 SHALL leave a state at the edge where an advancing tick makes elapsed ticks equal that state's duration; counter clears to 0 on every state change.
REQ-017 SHALL sequence NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> NS_GREEN.
REQ-018 SHALL, on leaving RED_A or RED_B with ped_pending=1, enter WALK instead, remembering the skipped green in a 1-bit next_dir register.
REQ-019 SHALL leave WALK after WALK_SEC ticks to NS_GREEN or EW_GREEN per next_dir.
REQ-020 SHALL set ped_pending on any cycle with ped_req=1 while state is not WALK; requests during WALK are ignored.
REQ-021 SHALL clear ped_pending at the edge entering WALK, taking priority over ped_req in that same cycle.
REQ-022 SHALL drive ns_light=green/yellow in NS_GREEN/NS_YELLOW, red otherwise; ew_light likewise for EW states; both red in RED_A, RED_B, WALK.
REQ-023 SHALL never show green or yellow on both directions simultaneously, nor walk=1 with any non-red light.
REQ-024 SHALL treat enable=0 during a tick as no tick (tick is not deferred).

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set state=NS_GREEN, counter=0, ped_pending=0, next_dir=0, ped_ack=0, walk=0, ns_light=3'b001, ew_light=3'b100.
REQ-026 SHALL give reset priority over enable, tick and ped_req, including mid-WALK and mid-count.

Structure
REQ-027 SHALL place state encodings, 3-bit light constants (RED=100, YEL=010, GRN=001) and default durations in shared package traffic_pkg.
REQ-028 SHALL use one sub-module phase_timer (4-bit tick counter with clear, enable, duration compare, done output).

Verification
REQ-029 SHALL check: reset, tick=1 every cycle, enable=1, no ped_req -> NS_GREEN 5 cycles, NS_YELLOW 2, RED_A 1, EW_GREEN 5, EW_YELLOW 2, RED_B 1, repeat.
REQ-030 SHALL check: ped_req 1-cycle pulse during NS_GREEN -> after RED_A, ped_ack pulses once, walk=1 for 4 ticks with both red, then EW_GREEN.
REQ-031 SHALL check: ped_req held high continuously -> WALK inserted after every RED phase; ped_ack once per WALK entry.
REQ-032 SHALL check: enable=0 for 10 cycles mid NS_GREEN with ticks present -> state and counter frozen, phase resumes with remaining ticks.
REQ-033 SHALL check: reset asserted during WALK -> next cycle ns_light=001, ew_light=100, walk=0, pending cleared.
REQ-034 SHALL check: ped_req in the cycle entering WALK -> pending clear after WALK; no second WALK following.
